// File: rtl/bird_pkg.sv
// Shared definitions for the bird control FSM and the bird datapath.
// Contents: control FSM state codes, pixel-engine states, screen size and
// default colour constants.
package bird_pkg;

  // State codes driven by the control FSM; the numeric values are shared.
  typedef enum logic [3:0] {
    ST_START   = 4'd0,
    ST_RAISING = 4'd1,
    ST_FALLING = 4'd2,
    ST_STOP    = 4'd3,
    ST_DRAW    = 4'd4,
    ST_UPDATE  = 4'd14,
    ST_DEL     = 4'd15
  } fsm_state_e;

  typedef enum logic [1:0] {
    ENG_IDLE,
    ENG_ERASE,
    ENG_DRAW
  } eng_state_e;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  localparam logic [2:0] BIRD_COLOUR_DEF = 3'b110;
  localparam logic [2:0] BG_COLOUR_DEF   = 3'b000;

endpackage

// File: rtl/bird_pixel_scan.sv
// Rectangle scanner for one sprite job: walks BIRD_W x BIRD_H pixels in
// raster order (column fastest), one pixel per cycle, first pixel the cycle
// after start.
// Ports:
//   clk, reset   - clock, synchronous active-high reset (aborts a job)
//   start        - begin a job (ignored while a job is running)
//   job_y        - top row of the rectangle
//   job_colour   - colour for every pixel of the job
//   x_out/y_out  - pixel coordinate (zero while idle)
//   colour       - pixel colour (BG_COLOUR while idle)
//   plot         - pixel valid
//   done         - high while the last pixel of the job is presented
module bird_pixel_scan
  import bird_pkg::*;
#(
  parameter int unsigned BIRD_X    = 20,
  parameter int unsigned BIRD_W    = 4,
  parameter int unsigned BIRD_H    = 4,
  parameter logic [2:0]  BG_COLOUR = BG_COLOUR_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] job_y,
  input  logic [2:0] job_colour,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       plot,
  output logic       done
);

  localparam logic [7:0] X0       = 8'(BIRD_X);
  localparam logic [7:0] COL_LAST = 8'(BIRD_W - 1);
  localparam logic [6:0] ROW_LAST = 7'(BIRD_H - 1);

  logic       active;
  logic [7:0] col;
  logic [6:0] row;
  logic [6:0] base_y;
  logic [2:0] colour_q;
  logic       last;

  assign last = (col == COL_LAST) && (row == ROW_LAST);
  assign done = active && last;

  always_ff @(posedge clk) begin
    if (reset) begin
      active   <= 1'b0;
      col      <= '0;
      row      <= '0;
      base_y   <= '0;
      colour_q <= BG_COLOUR;
    end else if (start && !active) begin
      active   <= 1'b1;
      col      <= '0;
      row      <= '0;
      base_y   <= job_y;
      colour_q <= job_colour;
    end else if (active) begin
      if (col == COL_LAST) begin
        col <= '0;
        if (last) begin
          active <= 1'b0;
          row    <= '0;
        end else begin
          row <= row + 7'd1;
        end
      end else begin
        col <= col + 8'd1;
      end
    end
  end

  assign plot   = active;
  assign x_out  = active ? X0 + col     : '0;
  assign y_out  = active ? base_y + row : '0;
  assign colour = active ? colour_q     : BG_COLOUR;

endmodule

// File: rtl/bird_datapath.sv
// Bird datapath: owns the bird's vertical position, reports rise-limit and
// collision status to the control FSM, and queues erase/draw sprite jobs
// for the 160x120 VGA adapter.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   state               - control FSM state code (actions fire on entry)
//   pipe_x, pipe_gap_y  - current pipe left column and gap top row
//   x_out, y_out        - VGA pixel coordinate
//   colour, plot        - VGA pixel colour and write enable
//   flag                - rise limit reached
//   touched             - collision with ceiling, ground or pipe
//   busy                - pixel engine running or a job pending
module bird_datapath
  import bird_pkg::*;
#(
  parameter int unsigned BIRD_X      = 20,
  parameter int unsigned BIRD_W      = 4,
  parameter int unsigned BIRD_H      = 4,
  parameter int unsigned START_Y     = 56,
  parameter int unsigned GROUND_Y    = 112,
  parameter int unsigned RISE_STEP   = 2,
  parameter int unsigned FALL_STEP   = 1,
  parameter int unsigned RISE_LIMIT  = 8,
  parameter int unsigned PIPE_W      = 8,
  parameter int unsigned GAP_H       = 32,
  parameter logic [2:0]  BIRD_COLOUR = BIRD_COLOUR_DEF,
  parameter logic [2:0]  BG_COLOUR   = BG_COLOUR_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] state,
  input  logic [7:0] pipe_x,
  input  logic [6:0] pipe_gap_y,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       plot,
  output logic       flag,
  output logic       touched,
  output logic       busy
);

  localparam logic [6:0] START_Y7 = 7'(START_Y);
  localparam logic [8:0] RISE9    = 9'(RISE_STEP);
  localparam logic [8:0] FALL9    = 9'(FALL_STEP);
  localparam logic [8:0] Y_MAX9   = 9'(GROUND_Y - BIRD_H);
  localparam logic [8:0] GROUND9  = 9'(GROUND_Y);
  localparam logic [8:0] H9       = 9'(BIRD_H);
  localparam logic [8:0] PIPE_W9  = 9'(PIPE_W);
  localparam logic [8:0] GAP9     = 9'(GAP_H);
  localparam logic [8:0] BL9      = 9'(BIRD_X);
  localparam logic [8:0] BR9      = 9'(BIRD_X + BIRD_W - 1);
  localparam logic [7:0] LIMIT8   = 8'(RISE_LIMIT);

  logic [3:0]  state_q;
  logic        entry;
  fsm_state_e  last_motion;
  logic [6:0]  bird_y;
  logic [7:0]  rise_cnt;
  logic        erase_pending, draw_pending;
  logic [6:0]  erase_y, draw_y;

  eng_state_e  eng_q, eng_next;
  logic        erase_start, draw_start, scan_start, scan_done;
  logic [6:0]  job_y;
  logic [2:0]  job_colour;

  // Physics and collision, all in 9-bit unsigned to avoid wrap.
  logic [8:0]  y9, bottom9, pipe_l9, pipe_r9, gap_top9, gap_bot9;
  logic [6:0]  rise_y, fall_y;
  logic [7:0]  rise_cnt_new;
  logic        overlap, touched_next;

  assign entry = (state != state_q);

  always_comb begin
    y9           = {2'b00, bird_y};
    rise_y       = (y9 >= RISE9) ? 7'(y9 - RISE9) : '0;
    fall_y       = (y9 + FALL9 > Y_MAX9) ? 7'(Y_MAX9) : 7'(y9 + FALL9);
    rise_cnt_new = (rise_cnt < LIMIT8) ? rise_cnt + 8'd1 : LIMIT8;
    bottom9      = y9 + H9;
    pipe_l9      = {1'b0, pipe_x};
    pipe_r9      = pipe_l9 + PIPE_W9 - 9'd1;
    gap_top9     = {2'b00, pipe_gap_y};
    gap_bot9     = gap_top9 + GAP9;
    overlap      = (BL9 <= pipe_r9) && (pipe_l9 <= BR9);
    touched_next = (y9 == 9'd0) || (bottom9 >= GROUND9) ||
                   (overlap && ((y9 < gap_top9) || (bottom9 > gap_bot9)));
  end

  // Pending bits are cleared on job start before the entry case so that a
  // request arriving in the same cycle re-arms the queue with its new y.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_START;
      last_motion   <= ST_START;
      bird_y        <= START_Y7;
      rise_cnt      <= '0;
      flag          <= 1'b0;
      touched       <= 1'b0;
      erase_pending <= 1'b0;
      draw_pending  <= 1'b0;
      erase_y       <= '0;
      draw_y        <= '0;
    end else begin
      state_q <= state;
      touched <= touched_next;
      if (erase_start) erase_pending <= 1'b0;
      if (draw_start)  draw_pending  <= 1'b0;
      if (entry) begin
        case (state)
          ST_START: begin
            last_motion <= ST_START;
            bird_y      <= START_Y7;
            rise_cnt    <= '0;
            flag        <= 1'b0;
          end
          ST_RAISING: last_motion <= ST_RAISING;
          ST_FALLING: begin
            last_motion <= ST_FALLING;
            rise_cnt    <= '0;
            flag        <= 1'b0;
          end
          ST_STOP: last_motion <= ST_STOP;
          ST_DEL: begin
            erase_pending <= 1'b1;
            erase_y       <= bird_y;
          end
          ST_UPDATE: begin
            if (last_motion == ST_RAISING) begin
              bird_y   <= rise_y;
              rise_cnt <= rise_cnt_new;
              flag     <= (rise_cnt_new >= LIMIT8);
            end else if (last_motion == ST_FALLING) begin
              bird_y <= fall_y;
            end
          end
          ST_DRAW: begin
            draw_pending <= 1'b1;
            draw_y       <= bird_y;
          end
          default: ;
        endcase
      end
    end
  end

  // Pixel engine: state register / next state / outputs.
  always_ff @(posedge clk) begin
    if (reset) eng_q <= ENG_IDLE;
    else       eng_q <= eng_next;
  end

  always_comb begin
    eng_next = eng_q;
    case (eng_q)
      ENG_IDLE: begin
        if (erase_pending)     eng_next = ENG_ERASE;
        else if (draw_pending) eng_next = ENG_DRAW;
      end
      ENG_ERASE, ENG_DRAW: if (scan_done) eng_next = ENG_IDLE;
      default: eng_next = ENG_IDLE;
    endcase
  end

  always_comb begin
    erase_start = (eng_q == ENG_IDLE) && erase_pending;
    draw_start  = (eng_q == ENG_IDLE) && !erase_pending && draw_pending;
    scan_start  = erase_start || draw_start;
    job_y       = erase_start ? erase_y : draw_y;
    job_colour  = erase_start ? BG_COLOUR : BIRD_COLOUR;
  end

  assign busy = (eng_q != ENG_IDLE) || erase_pending || draw_pending;

  bird_pixel_scan #(
    .BIRD_X   (BIRD_X),
    .BIRD_W   (BIRD_W),
    .BIRD_H   (BIRD_H),
    .BG_COLOUR(BG_COLOUR)
  ) u_scan (
    .clk       (clk),
    .reset     (reset),
    .start     (scan_start),
    .job_y     (job_y),
    .job_colour(job_colour),
    .x_out     (x_out),
    .y_out     (y_out),
    .colour    (colour),
    .plot      (plot),
    .done      (scan_done)
  );

endmodule

// File: tb/tb_bird_datapath.sv
module tb_bird_datapath;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] state;
  logic [7:0] pipe_x;
  logic [6:0] pipe_gap_y;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       plot, flag, touched, busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bird_datapath dut (
    .clk       (clk),
    .reset     (reset),
    .state     (state),
    .pipe_x    (pipe_x),
    .pipe_gap_y(pipe_gap_y),
    .x_out     (x_out),
    .y_out     (y_out),
    .colour    (colour),
    .plot      (plot),
    .flag      (flag),
    .touched   (touched),
    .busy      (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Checks 16 consecutive pixels of one job; entered with pixel 0 visible.
  task automatic scan_job(input int y0, input int col, input string tag);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("%s px%0d {plot,x,y,colour}", tag, r * 4 + c),
            {plot, x_out, y_out, colour},
            {1'b1, 8'(20 + c), 7'(y0 + r), 3'(col)});
        tick();
      end
    end
  endtask

  task automatic wait_plot(input string tag, input int max_cycles);
    int n = 0;
    while (plot !== 1'b1 && n < max_cycles) begin
      tick();
      n++;
    end
    chk({tag, " plot start"}, plot, 1);
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    int n = 0;
    while (busy !== 1'b0 && n < max_cycles) begin
      tick();
      n++;
    end
    chk({tag, " busy clear"}, busy, 0);
  endtask

  initial begin
    int exp_y;
    int plots;
    int px_tab[12]  = '{18, 18, 30, 24, 23, 13, 12, 18, 18, 18, 18, 250};
    int gap_tab[12] = '{70, 50, 70, 70, 70, 70, 70, 56, 57, 28, 27, 0};
    int exp_tab[12] = '{1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 1, 0};

    reset      = 1'b1;
    state      = 4'd0;
    pipe_x     = 8'd100;
    pipe_gap_y = 7'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset plot", plot, 0);
    chk("reset x/y/colour", {x_out, y_out, colour}, 0);
    chk("reset flag", flag, 0);
    chk("reset touched", touched, 0);
    chk("reset busy", busy, 0);
    reset = 1'b0;
    tick();
    chk("post-reset touched", touched, 0);
    chk("post-reset busy", busy, 0);

    // DEL -> UPDATE -> DRAW, one cycle each, exact pixel timing
    state = 4'd15; tick();
    chk("del busy", busy, 1);
    chk("del plot", plot, 0);
    state = 4'd14; tick();
    state = 4'd4;
    scan_job(56, 0, "erase56");
    chk("gap plot", plot, 0);
    chk("gap busy", busy, 1);
    tick();
    scan_job(56, 6, "draw56");
    chk("after draw plot", plot, 0);
    chk("after draw busy", busy, 0);

    // Raising: 8 loops, flag on the 8th update
    state = 4'd1; tick();
    for (int i = 1; i <= 8; i++) begin
      state = 4'd15; tick();
      state = 4'd14; tick();
      chk($sformatf("rise%0d flag", i), flag, (i == 8) ? 1 : 0);
      state = 4'd4; tick();
      wait_idle($sformatf("rise%0d", i), 100);
    end
    state = 4'd15; tick();
    state = 4'd4; tick();
    wait_plot("erase40", 10);
    scan_job(40, 0, "erase40");
    wait_plot("draw40", 10);
    scan_job(40, 6, "draw40");
    chk("raised flag held", flag, 1);
    state = 4'd2; tick();
    chk("falling entry flag", flag, 0);

    // Falling from 56 saturates at 108; touched follows one cycle later
    state = 4'd0; tick();
    state = 4'd2; tick();
    exp_y = 56;
    for (int i = 0; i < 55; i++) begin
      state = 4'd14; tick();
      exp_y = (exp_y + 1 > 108) ? 108 : exp_y + 1;
      state = 4'd2; tick();
      chk($sformatf("fall y=%0d touched", exp_y), touched, (exp_y + 4 >= 112) ? 1 : 0);
    end
    state = 4'd4; tick();
    wait_plot("draw108", 10);
    scan_job(108, 6, "draw108");
    wait_idle("draw108", 10);

    // Ceiling: rise from 56 until y saturates at 0
    state = 4'd0; tick();
    state = 4'd1; tick();
    exp_y = 56;
    for (int i = 0; i < 30; i++) begin
      state = 4'd14; tick();
      exp_y = (exp_y < 2) ? 0 : exp_y - 2;
      state = 4'd1; tick();
      chk($sformatf("ceil y=%0d touched", exp_y), touched, (exp_y == 0) ? 1 : 0);
    end
    chk("ceiling flag", flag, 1);

    // Pipe collision at bird_y=56
    state = 4'd0; tick();
    for (int i = 0; i < 12; i++) begin
      pipe_x     = 8'(px_tab[i]);
      pipe_gap_y = 7'(gap_tab[i]);
      tick();
      chk($sformatf("pipe x=%0d gap=%0d touched", px_tab[i], gap_tab[i]), touched, exp_tab[i]);
    end
    pipe_x     = 8'd100;
    pipe_gap_y = 7'd0;
    tick();

    // Reset in the middle of an erase job with a draw queued
    state = 4'd15; tick();
    state = 4'd4; tick();
    repeat (4) tick();
    chk("mid-job pixel4 {plot,x,y,colour}", {plot, x_out, y_out, colour},
        {1'b1, 8'd20, 7'd57, 3'd0});
    reset = 1'b1;
    state = 4'd0;
    tick();
    chk("abort plot", plot, 0);
    chk("abort busy", busy, 0);
    chk("abort x/y/colour", {x_out, y_out, colour}, 0);
    reset = 1'b0;
    plots = 0;
    repeat (40) begin
      tick();
      if (plot === 1'b1) plots++;
    end
    chk("no job after abort", plots, 0);
    chk("idle after abort busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bird_datapath.md
Name: bird_datapath

Overview:
- Datapath stage directly downstream of the bird control FSM.
- Consumes the FSM's 4-bit state code and owns the bird's vertical position.
- Produces the `flag` (risen too high) and `touched` (collision) status back to the FSM.
- Emits erase/draw pixel streams (x, y, colour, plot) to the 160x120 VGA adapter.

Parameters:
- BIRD_X, 20, fixed left column of sprite
- BIRD_W, 4, sprite width in pixels
- BIRD_H, 4, sprite height in pixels
- START_Y, 56, y loaded in START
- GROUND_Y, 112, first row of ground; bird bottom must stay above it
- RISE_STEP, 2, pixels moved up per UPDATE while raising
- FALL_STEP, 1, pixels moved down per UPDATE while falling
- RISE_LIMIT, 8, UPDATEs in raising before `flag` asserts
- PIPE_W, 8, pipe width
- GAP_H, 32, pipe gap height
- BIRD_COLOUR, 3'b110, draw colour
- BG_COLOUR, 3'b000, erase colour

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- state  in  4  FSM state code (START=0, RAISING=1, FALLING=2, STOP=3, DRAW=4, UPDATE=14, DEL=15)
- pipe_x  in  8  left column of current pipe
- pipe_gap_y  in  7  top row of pipe gap
- x_out  out  8  VGA pixel x
- y_out  out  7  VGA pixel y
- colour  out  3  VGA pixel colour
- plot  out  1  VGA write enable
- flag  out  1  rise limit reached
- touched  out  1  collision with ceiling, ground or pipe
- busy  out  1  pixel engine active or job pending

Behaviour:
- Reset (synchronous, active-high; resets everything, including mid-job):
  - bird_y=START_Y, rise_cnt=0, last_motion=START, state_q=START, flag=0, touched=0.
  - plot=0, x_out=0, y_out=0, colour=BG_COLOUR, busy=0; pending jobs cleared, any running job aborted.
- Entry detect: `state` is registered as state_q; an entry event is the cycle where state != state_q. Each action below fires once per entry, never per cycle of dwell.
- Entry to START, RAISING, FALLING or STOP: last_motion <= state.
  - START additionally: bird_y=START_Y, rise_cnt=0, flag=0.
  - FALLING additionally: rise_cnt=0, flag=0.
- Entry to DEL: erase_pending=1, erase_y=bird_y (pre-update snapshot).
- Entry to UPDATE (bird_y and touched registered, visible the next cycle):
  - last_motion RAISING: bird_y = max(bird_y-RISE_STEP, 0); rise_cnt saturates at RISE_LIMIT; flag = (rise_cnt_new >= RISE_LIMIT).
  - last_motion FALLING: bird_y = min(bird_y+FALL_STEP, GROUND_Y-BIRD_H).
  - last_motion START or STOP: bird_y unchanged.
- Entry to DRAW: draw_pending=1, draw_y=bird_y (post-update).
- touched, recomputed every cycle from bird_y and registered (one-cycle latency). Set if any of:
  - bird_y==0;
  - bird_y+BIRD_H >= GROUND_Y;
  - horizontal overlap ([BIRD_X, BIRD_X+BIRD_W-1] intersects [pipe_x, pipe_x+PIPE_W-1]) AND (bird_y < pipe_gap_y OR bird_y+BIRD_H > pipe_gap_y+GAP_H).
- Width rule: all comparisons use 9-bit unsigned intermediates; no wrap on pipe_x+PIPE_W near 255.
- Pixel engine FSM, states IDLE, ERASE, DRAW:
  - IDLE: if erase_pending, go to ERASE (erase has priority); else if draw_pending, go to DRAW. The pending bit clears on job start.
  - Each job scans BIRD_W*BIRD_H pixels in raster order (col fastest), one per cycle, first pixel the cycle after start.
  - During a job: plot=1, x_out=BIRD_X+col, y_out=job_y+row, colour=BG_COLOUR (erase) or BIRD_COLOUR (draw).
  - After the last pixel, return to IDLE; plot=0 in IDLE.
- Jobs are never aborted except by reset. A re-request for a job type already pending overwrites its snapshot y; the request is not duplicated.
- busy = (engine != IDLE) | erase_pending | draw_pending.
- Simultaneous events: an entry event and a job completion in the same cycle are both honoured.

Decomposition:
- Shared package bird_pkg: state-code localparams (shared with the control FSM), screen dimensions 160x120, colour constants.
- One sub-module, bird_pixel_scan: col/row counters, start/done, x/y/colour/plot generation for one rectangle job.
- The top module holds position/physics, collision and the job queue.

Test Plan:
- Reset held 2 cycles then released, state=0 -> bird_y=56, plot=0, flag=0, touched=0, busy=0.
- state sequence 0->15->14->4, one cycle each -> 16 plot cycles at y 56..59, colour 000, then 16 at y 56..59, colour 110; x 20..23; busy drops after the 32nd pixel.
- Enter RAISING, then 8 DEL/UPDATE/DRAW loops -> bird_y=40, flag=1 the cycle after the 8th UPDATE; entering FALLING -> flag=0.
- FALLING loops from y=56 -> bird_y saturates at 108; touched=1 the cycle after y reaches 108.
- pipe_x=18, pipe_gap_y=70, bird_y=56 -> touched=1; with pipe_gap_y=50 -> touched=0; with pipe_x=30 -> touched=0.
- Reset asserted at the 5th pixel of an erase job -> plot=0 next cycle, busy=0, no draw job follows.
